// File: rtl/c1_chk_rx_if.sv
// Stream-in / result-out bundle for the one's-complement checksum checker.
`timescale 1ns/1ps
interface c1_chk_rx_if #(
  parameter int W  = 4,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic          out_ok;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_len;
  logic          out_ovf;

  // Producer of words and consumer of results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_ok, out_sum, out_len, out_ovf
  );

  // The checker itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_ok, out_sum, out_len, out_ovf
  );
endinterface

// File: rtl/c1_chk_rx.sv
// Receive-side checker for one's-complement checksummed word streams.
// Folds every word (checksum included) with end-around carry and reports the
// final sum, pass/fail and beat count through a held result handshake.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  ACC   | accepting words, accumulating; result registers hold last result
//  RESP  | result presented on out_*, input stalled until out_ready
`timescale 1ns/1ps
module c1_chk_rx #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  c1_chk_rx_if.slave  bus
);

  typedef enum logic {ACC = 1'b0, RESP = 1'b1} state_t;

  localparam logic [W-1:0]  ALL_ONES = '1;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        state, state_nxt;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic          beat;
  logic [W-1:0]  acc_sum;
  logic [CW-1:0] cnt_inc;
  logic          ovf_inc;

  // The second add cannot carry out: the first sum is at most 2*(2**W-1).
  function automatic logic [W-1:0] c1add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W-1:0] + W'(s[W]);
  endfunction

  assign beat    = bus.in_valid && (state == ACC);
  assign acc_sum = c1add(acc, bus.in_data);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign ovf_inc = ovf || (cnt_inc == CNT_MAX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ACC: begin
        bus.in_ready = 1'b1;
        if (beat && bus.in_last) state_nxt = RESP;
      end
      RESP: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  // Accumulator, saturating beat counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      bus.out_ok  <= 1'b0;
      bus.out_sum <= '0;
      bus.out_len <= '0;
      bus.out_ovf <= 1'b0;
    end else if (beat) begin
      if (bus.in_last) begin
        bus.out_sum <= acc_sum;
        bus.out_ok  <= (acc_sum == ALL_ONES);
        bus.out_len <= cnt_inc;
        bus.out_ovf <= ovf_inc;
        acc         <= '0;
        cnt         <= '0;
        ovf         <= 1'b0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt_inc;
        ovf <= ovf_inc;
      end
    end
  end

endmodule

// File: tb/tb_c1_chk_rx.sv
// Bench for c1_chk_rx: two instances (CW=8 and CW=2) see the same stream so
// counter saturation is exercised on short messages as well.
`timescale 1ns/1ps
module tb_c1_chk_rx;
  localparam int W   = 4;
  localparam int CW  = 8;
  localparam int CW2 = 2;
  localparam int MAXA = (1 << CW) - 1;
  localparam int MAXB = (1 << CW2) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  c1_chk_rx_if #(.W(W), .CW(CW))  bus_a ();
  c1_chk_rx_if #(.W(W), .CW(CW2)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.in_last   = in_last;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_last   = in_last;
  assign bus_b.out_ready = out_ready;

  c1_chk_rx #(.W(W), .CW(CW))  dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  c1_chk_rx #(.W(W), .CW(CW2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;
  int msg[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One's-complement sum: total folded modulo 2**W-1, with +0 only when
  // every word is zero.
  function automatic int ref_sum();
    int total = 0;
    foreach (msg[i]) total += msg[i];
    return (total == 0) ? 0 : (total - 1) % ((1 << W) - 1) + 1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy_a"}, bus_a.in_ready, 1);
    chk({tag, "_vld_a"}, bus_a.out_valid, 0);
    chk({tag, "_ok_a"},  bus_a.out_ok, 0);
    chk({tag, "_sum_a"}, bus_a.out_sum, 0);
    chk({tag, "_len_a"}, bus_a.out_len, 0);
    chk({tag, "_ovf_a"}, bus_a.out_ovf, 0);
    chk({tag, "_vld_b"}, bus_b.out_valid, 0);
    chk({tag, "_len_b"}, bus_b.out_len, 0);
    chk({tag, "_ovf_b"}, bus_b.out_ovf, 0);
  endtask

  task automatic send_msg(input bit do_last);
    for (int i = 0; i < msg.size(); i++) begin
      int n = 0;
      in_valid = 1'b1;
      in_data  = W'(msg[i]);
      in_last  = do_last && (i == msg.size() - 1);
      while (bus_a.in_ready !== 1'b1 && n < 50) begin
        @(posedge clk); #1; n++;
      end
      chk("in_ready", bus_a.in_ready, 1);
      if (i == msg.size() - 1) chk("vld_before_last", bus_a.out_valid, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'bx;
  endtask

  task automatic expect_result(input int hold);
    int s, n;
    s = ref_sum();
    n = msg.size();
    for (int c = 0; c <= hold; c++) begin
      chk("out_valid_a", bus_a.out_valid, 1);
      chk("out_valid_b", bus_b.out_valid, 1);
      chk("in_ready_resp", bus_a.in_ready, 0);
      chk("out_sum_a", bus_a.out_sum, s);
      chk("out_ok_a",  bus_a.out_ok, (s == (1 << W) - 1) ? 1 : 0);
      chk("out_len_a", bus_a.out_len, (n < MAXA) ? n : MAXA);
      chk("out_ovf_a", bus_a.out_ovf, (n >= MAXA) ? 1 : 0);
      chk("out_sum_b", bus_b.out_sum, s);
      chk("out_len_b", bus_b.out_len, (n < MAXB) ? n : MAXB);
      chk("out_ovf_b", bus_b.out_ovf, (n >= MAXB) ? 1 : 0);
      if (c < hold) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after", bus_a.in_ready, 1);
    chk("out_valid_after", bus_a.out_valid, 0);
    chk("out_sum_held", bus_a.out_sum, s);
  endtask

  initial begin
    in_data = 'x;
    in_last = 1'bx;
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst1");

    // Basic message; checksum 0 makes the sum all ones.
    msg = '{3, 5, 7, 0};
    send_msg(1); expect_result(0);

    // End-around carry wrap.
    msg = '{9, 8, 13};
    send_msg(1); expect_result(0);

    // Corrupted checksum with downstream backpressure.
    msg = '{9, 8, 12};
    send_msg(1); expect_result(3);

    // Asynchronous reset part way through a message.
    msg = '{1, 2};
    send_msg(0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    msg = '{0, 15};
    send_msg(1); expect_result(0);

    // One-beat message and +0 failing.
    msg = '{6};
    send_msg(1); expect_result(0);
    msg = '{0, 0};
    send_msg(1); expect_result(0);

    // Saturation on the narrow counter, then cleared on the next message.
    msg = '{1, 2, 3, 4, 5};
    send_msg(1); expect_result(1);
    msg = '{6, 7};
    send_msg(1); expect_result(0);

    // Saturation on the wide counter.
    msg = {};
    for (int i = 0; i < 260; i++) msg.push_back(int'($urandom_range(0, 15)));
    send_msg(1); expect_result(0);

    // Random messages, half with a correct checksum, with idle gaps.
    for (int m = 0; m < 40; m++) begin
      int len;
      len = int'($urandom_range(1, 7));
      msg = {};
      for (int i = 0; i < len - 1; i++) msg.push_back(int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) msg.push_back(15 - ref_sum());
      else                           msg.push_back(int'($urandom_range(0, 15)));
      repeat (int'($urandom_range(0, 2))) begin
        @(posedge clk); #1;
        chk("idle_vld", bus_a.out_valid, 0);
      end
      send_msg(1);
      expect_result(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
